// File: rtl/clock_pkg.sv
// clock_pkg
// Shared field widths, field limits and the 12-hour display decode for the
// time-of-day core. No ports; imported by clock_hms_core.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // 0 -> 12, 1..12 unchanged, 13..23 -> hour24-12
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour24);
    if (hour24 == 5'd0)
      return 5'd12;
    else if (hour24 > 5'd12)
      return hour24 - 5'd12;
    else
      return hour24;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides the enabled system clock down to a once-per-second strobe.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   en       in  count enable; the counter holds when low
//   clr      in  restart the second (used by a time-set load)
//   tick_pre out combinational strobe, high in the cycle whose edge advances
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_pre
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_term;

  // With TICKS_PER_SEC=1 the counter stays at 0 and every enabled cycle ticks.
  assign w_term   = (r_cnt == TERM);
  assign tick_pre = en & w_term;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (en) begin
      if (w_term)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/clock_hms_core.sv
// clock_hms_core
// Seconds/minutes/hours time-of-day counter with run-time 12/24-hour display,
// validated time-set load and a one-shot HH:MM alarm.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   en                         counting enable
//   mode24                     1 = 24-hour display, 0 = 12-hour display
//   set_valid/_hour/_min/_sec  time load request (24-hour encoding)
//   alarm_en/_hour/_min        alarm arm and compare time
//   sec, min, hour, pm         current time (hour/pm decoded from hour24)
//   tick, alarm, set_err       one-cycle registered pulses
module clock_hms_core
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode24,
  input  logic              set_valid,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              pm,
  output logic              tick,
  output logic              alarm,
  output logic              set_err
);

  logic [SEC_W-1:0]  r_sec;
  logic [MIN_W-1:0]  r_min;
  logic [HOUR_W-1:0] r_hour24;
  logic              r_tick;
  logic              r_alarm;
  logic              r_set_err;

  logic              w_tick_pre;
  logic              w_set_ok;
  logic              w_set_load;
  logic              w_adv;
  logic              w_alarm_hit;
  logic [SEC_W-1:0]  w_sec_nxt;
  logic [MIN_W-1:0]  w_min_nxt;
  logic [HOUR_W-1:0] w_hour_nxt;

  assign w_set_ok   = (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
  assign w_set_load = set_valid & w_set_ok;

  // A valid load restarts the second, so the prescaler clear also swallows
  // any advance that would have landed on the same edge.
  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (w_set_load),
    .tick_pre(w_tick_pre)
  );

  assign w_adv = w_tick_pre & ~w_set_load;

  // Full carry chain resolved combinationally so all fields update at one edge.
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour24;
    if (r_sec == SEC_MAX) begin
      w_sec_nxt = '0;
      if (r_min == MIN_MAX) begin
        w_min_nxt  = '0;
        w_hour_nxt = (r_hour24 == HOUR_MAX) ? '0 : r_hour24 + HOUR_W'(1);
      end else begin
        w_min_nxt = r_min + MIN_W'(1);
      end
    end else begin
      w_sec_nxt = r_sec + SEC_W'(1);
    end
  end

  // Next-time values are always in range, so out-of-range alarm inputs never hit.
  assign w_alarm_hit = alarm_en && (w_sec_nxt == '0) &&
                       (w_min_nxt == alarm_min) && (w_hour_nxt == alarm_hour);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec     <= '0;
      r_min     <= '0;
      r_hour24  <= '0;
      r_tick    <= 1'b0;
      r_alarm   <= 1'b0;
      r_set_err <= 1'b0;
    end else begin
      r_tick    <= w_adv;
      r_alarm   <= w_adv & w_alarm_hit;
      r_set_err <= set_valid & ~w_set_ok;
      if (w_set_load) begin
        r_sec    <= set_sec;
        r_min    <= set_min;
        r_hour24 <= set_hour;
      end else if (w_adv) begin
        r_sec    <= w_sec_nxt;
        r_min    <= w_min_nxt;
        r_hour24 <= w_hour_nxt;
      end
    end
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = mode24 ? r_hour24 : to_12h(r_hour24);
  assign pm      = (r_hour24 >= 5'd12);
  assign tick    = r_tick;
  assign alarm   = r_alarm;
  assign set_err = r_set_err;

endmodule
